// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-requester data memory arbiter with read-modify-write sequencing
module dmem_arbiter #(
   parameter int ARB_MODE = 1,
   parameter int ADDR_W   = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              r0_req,
   input  logic              r0_we,
   input  logic [3:0]        r0_be,
   input  logic [ADDR_W-1:0] r0_addr,
   input  logic [31:0]       r0_wdata,
   output logic              r0_gnt,
   output logic              r0_rvalid,
   output logic [31:0]       r0_rdata,
   input  logic              r1_req,
   input  logic              r1_we,
   input  logic [3:0]        r1_be,
   input  logic [ADDR_W-1:0] r1_addr,
   input  logic [31:0]       r1_wdata,
   output logic              r1_gnt,
   output logic              r1_rvalid,
   output logic [31:0]       r1_rdata,
   output logic              mem_ren,
   output logic              mem_wen,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q;
   logic              we_q;
   logic [3:0]        be_q;
   logic [31:0]       wdata_q;
   logic [31:0]       rdata_q;
   logic              id_q;
   logic              last_q;

   logic              any_req;
   logic              win;
   logic              sel_we;
   logic [3:0]        sel_be;
   logic [ADDR_W-1:0] sel_addr;
   logic [31:0]       sel_wdata;
   logic [31:0]       merged;

   // The memory only sees whole words; the byte offset is dropped here.
   assign mem_addr  = addr_q & ~(ADDR_W'(3));
   assign mem_wdata = wdata_q;

   // Pick the winner among pending requests and mux its fields.
   always_comb begin
      any_req = r0_req | r1_req;
      win     = 1'b0;
      if (r0_req && r1_req) begin
         win = (ARB_MODE != 0) ? ~last_q : 1'b0;
      end else if (r1_req) begin
         win = 1'b1;
      end
      sel_we    = win ? r1_we    : r0_we;
      sel_be    = win ? r1_be    : r0_be;
      sel_addr  = win ? r1_addr  : r0_addr;
      sel_wdata = win ? r1_wdata : r0_wdata;
   end

   // Merge the latched store bytes over the word read back from memory.
   always_comb begin
      merged = '0;
      for (int i = 0; i < 4; i++) begin
         merged[8*i +: 8] = be_q[i] ? wdata_q[8*i +: 8] : mem_rdata[8*i +: 8];
      end
   end

   // State register; reset also kills mem_wen immediately since it decodes WR.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state, grants, memory strobes and completion pulses.
   always_comb begin
      state_d   = state_q;
      r0_gnt    = 1'b0;
      r1_gnt    = 1'b0;
      mem_ren   = 1'b0;
      mem_wen   = 1'b0;
      r0_rvalid = 1'b0;
      r1_rvalid = 1'b0;
      r0_rdata  = 32'h0;
      r1_rdata  = 32'h0;
      case (state_q)
         IDLE: begin
            // Grants are suppressed while reset is held so outputs stay quiet.
            if (any_req && rst_n) begin
               r0_gnt = ~win;
               r1_gnt = win;
               if (!sel_we) begin
                  state_d = RD;
               end else if (sel_be == 4'hF) begin
                  state_d = WR;
               end else if (sel_be == 4'h0) begin
                  state_d = RESP;
               end else begin
                  state_d = RD;
               end
            end
         end
         RD: begin
            mem_ren = 1'b1;
            state_d = we_q ? WR : RESP;
         end
         WR: begin
            mem_wen = 1'b1;
            state_d = RESP;
         end
         RESP: begin
            if (id_q) begin
               r1_rvalid = 1'b1;
               r1_rdata  = rdata_q;
            end else begin
               r0_rvalid = 1'b1;
               r0_rdata  = rdata_q;
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Request latch at grant, then read capture or merge during RD.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q  <= '0;
         we_q    <= 1'b0;
         be_q    <= 4'h0;
         wdata_q <= 32'h0;
         rdata_q <= 32'h0;
         id_q    <= 1'b0;
         last_q  <= 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (any_req) begin
                  addr_q  <= sel_addr;
                  we_q    <= sel_we;
                  be_q    <= sel_be;
                  wdata_q <= sel_wdata;
                  rdata_q <= 32'h0;
                  id_q    <= win;
                  last_q  <= win;
               end
            end
            RD: begin
               if (we_q) begin
                  wdata_q <= merged;
               end else begin
                  rdata_q <= mem_rdata;
               end
            end
            WR: begin
               rdata_q <= 32'h0;
            end
            default: ;
         endcase
      end
   end

endmodule
